// File: rtl/apes_acq_seq.sv
// apes_acq_seq: acquisition sequencer for the APES counter chain (arm, start, collect, per-channel readout, clear).
// Optional readout watchdog enabled by defining APES_ACQ_SEQ_RDTMO_EN; without it READOUT waits indefinitely.
module apes_acq_seq #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int COLLECT_MAX = 0,
  parameter int COLLECT_W   = 16,
  parameter int CLR_CYCLES  = 2,
  parameter int CYC_W       = 16,
  parameter int RD_TMO      = 1024
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              hven_cmd,
  input  logic              reset_cmd,
  input  logic              abort_cmd,
  input  logic              auto_rearm,
  input  logic              collect_done,
  input  logic              rdout_done,
  output logic              cnt_start,
  output logic              cnt_clr,
  output logic [NUM_CH-1:0] rd_en,
  output logic [CH_W-1:0]   rd_ch,
  output logic              busy,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic              seq_err,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_START   = 3'd2,
    S_COLLECT = 3'd3,
    S_READOUT = 3'd4,
    S_NEXT    = 3'd5,
    S_CLEAR   = 3'd6
  } state_t;

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [COLLECT_W-1:0] COL_LAST = (COLLECT_MAX == 0) ? '0 : COLLECT_W'(COLLECT_MAX - 1);
  localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [NUM_CH-1:0]    CH0_EN   = NUM_CH'(1);

  if (NUM_CH < 2 || NUM_CH > 16 || (1 << CH_W) < NUM_CH || CLR_CYCLES < 1 || RD_TMO < 2) begin : g_param_check
    $error("apes_acq_seq: illegal parameter set");
  end

  state_t               state;
  logic [COLLECT_W-1:0] col_tmr;
  logic [CLR_W-1:0]     clr_tmr;
  logic                 collect_exit;
  logic                 rd_timeout;

  // collect_done and the internal window limit are one and the same exit
  assign collect_exit = collect_done || ((COLLECT_MAX != 0) && (col_tmr == COL_LAST));
  assign state_o      = state;

`ifdef APES_ACQ_SEQ_RDTMO_EN
  localparam int TMO_W = $clog2(RD_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TMO - 1);
  logic [TMO_W-1:0] wd_tmr;
  assign rd_timeout = (wd_tmr == TMO_LAST);
`else
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt_start <= 1'b0;
      cnt_clr   <= 1'b0;
      rd_en     <= '0;
      rd_ch     <= '0;
      busy      <= 1'b0;
      cycle_cnt <= '0;
      seq_err   <= 1'b0;
      col_tmr   <= '0;
      clr_tmr   <= '0;
`ifdef APES_ACQ_SEQ_RDTMO_EN
      wd_tmr    <= '0;
`endif
    end else if (abort_cmd && (state inside {S_START, S_COLLECT, S_READOUT, S_NEXT})) begin
      // abort runs a full clear but is not counted as a completed sequence
      state     <= S_CLEAR;
      busy      <= 1'b1;
      cnt_start <= 1'b0;
      rd_en     <= '0;
      cnt_clr   <= 1'b1;
      clr_tmr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hven_cmd) state <= S_ARMED;
        end
        S_ARMED: begin
          if (!hven_cmd) begin
            state <= S_IDLE;
          end else if (reset_cmd) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          cnt_start <= 1'b1;
          col_tmr   <= '0;
          seq_err   <= 1'b0;
          state     <= S_COLLECT;
        end
        S_COLLECT: begin
          col_tmr <= col_tmr + COLLECT_W'(1);
          if (collect_exit) begin
            cnt_start <= 1'b0;
            rd_ch     <= '0;
            rd_en     <= CH0_EN;
            state     <= S_READOUT;
`ifdef APES_ACQ_SEQ_RDTMO_EN
            wd_tmr    <= '0;
`endif
          end
        end
        S_READOUT: begin
          if (rdout_done) begin
            rd_en <= '0;
            if (rd_ch == CH_LAST) begin
              state   <= S_CLEAR;
              cnt_clr <= 1'b1;
              clr_tmr <= '0;
              if (!(&cycle_cnt)) cycle_cnt <= cycle_cnt + CYC_W'(1);
            end else begin
              rd_ch <= rd_ch + CH_W'(1);
              state <= S_NEXT;
            end
          end else if (rd_timeout) begin
`ifdef APES_ACQ_SEQ_RDTMO_EN
            seq_err <= 1'b1;
`endif
            rd_en   <= '0;
            state   <= S_CLEAR;
            cnt_clr <= 1'b1;
            clr_tmr <= '0;
          end else begin
`ifdef APES_ACQ_SEQ_RDTMO_EN
            wd_tmr <= wd_tmr + TMO_W'(1);
`endif
          end
        end
        S_NEXT: begin
          rd_en <= CH0_EN << rd_ch;
          state <= S_READOUT;
`ifdef APES_ACQ_SEQ_RDTMO_EN
          wd_tmr <= '0;
`endif
        end
        S_CLEAR: begin
          if (clr_tmr == CLR_LAST) begin
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            state   <= (auto_rearm && hven_cmd) ? S_ARMED : S_IDLE;
          end else begin
            clr_tmr <= clr_tmr + CLR_W'(1);
          end
        end
        default: begin
          // unreachable encoding: recover to a clean idle
          state     <= S_IDLE;
          cnt_start <= 1'b0;
          cnt_clr   <= 1'b0;
          rd_en     <= '0;
          rd_ch     <= '0;
          busy      <= 1'b0;
          cycle_cnt <= '0;
          seq_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apes_acq_seq.sv
// tb_apes_acq_seq: scoreboard bench for apes_acq_seq; the driver pushes expected output events, a negedge monitor pops them.
// Watchdog scenarios are included when APES_ACQ_SEQ_RDTMO_EN is defined.
module tb_apes_acq_seq;
  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int COLLECT_MAX = 100;
  localparam int COLLECT_W   = 16;
  localparam int CLR_CYCLES  = 2;
  localparam int CYC_W       = 2;
  localparam int RD_TMO      = 16;
  localparam int MAX_CYC     = (1 << CYC_W) - 1;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic hven_cmd = 1'b0, reset_cmd = 1'b0, abort_cmd = 1'b0, auto_rearm = 1'b0;
  logic collect_done = 1'b0, rdout_done = 1'b0;
  logic              cnt_start, cnt_clr, busy, seq_err;
  logic [NUM_CH-1:0] rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [CYC_W-1:0]  cycle_cnt;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  int m_cyc = 0;

  apes_acq_seq #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .COLLECT_MAX(COLLECT_MAX), .COLLECT_W(COLLECT_W),
    .CLR_CYCLES(CLR_CYCLES), .CYC_W(CYC_W), .RD_TMO(RD_TMO)
  ) dut (
    .clk50(clk50), .rst_n(rst_n), .hven_cmd(hven_cmd), .reset_cmd(reset_cmd),
    .abort_cmd(abort_cmd), .auto_rearm(auto_rearm), .collect_done(collect_done),
    .rdout_done(rdout_done), .cnt_start(cnt_start), .cnt_clr(cnt_clr), .rd_en(rd_en),
    .rd_ch(rd_ch), .busy(busy), .cycle_cnt(cycle_cnt), .seq_err(seq_err), .state_o(state_o)
  );

  // clock / reset
  always #10 clk50 = ~clk50;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // event word: kind, then four small fields
  function automatic logic [31:0] ev(input int kind, input int a, input int b, input int c, input int d);
    logic [31:0] w;
    w = {kind[3:0], a[3:0], b[7:0], c[7:0], d[7:0]};
    return w;
  endfunction

  function automatic void pop_cmp(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected no event", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endfunction

  // monitor / scoreboard
  initial begin
    int col_len, hi_len, clr_len, gap;
    logic p_start, p_clr;
    logic [NUM_CH-1:0] p_rd;
    col_len = 0; hi_len = 0; clr_len = 0; gap = 0;
    p_start = 1'b0; p_clr = 1'b0; p_rd = '0;
    forever begin
      @(negedge clk50);
      if (!rst_n) begin
        col_len = 0; hi_len = 0; clr_len = 0; gap = 0;
        p_start = 1'b0; p_clr = 1'b0; p_rd = '0;
      end else begin
        check("busy_vs_state", busy, (state_o >= 3'd2) && (state_o <= 3'd6));
        if (p_start && !cnt_start) pop_cmp("collect_len", ev(2, 0, 0, 0, col_len));
        if (p_rd == 0 && rd_en != 0) pop_cmp("rd_rise", ev(1, 0, gap, rd_ch, rd_en));
        if (p_rd != 0 && rd_en == 0) pop_cmp("rd_len", ev(4, 0, 0, 0, hi_len));
        if (p_clr && !cnt_clr) pop_cmp("clear", ev(3, seq_err, clr_len, cycle_cnt, state_o));
        col_len = cnt_start ? col_len + 1 : 0;
        hi_len  = (rd_en != 0) ? hi_len + 1 : 0;
        clr_len = cnt_clr ? clr_len + 1 : 0;
        gap     = (rd_en == 0 && !cnt_start) ? gap + 1 : 0;
        p_start = cnt_start; p_clr = cnt_clr; p_rd = rd_en;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic go_armed();
    hven_cmd = 1'b1;
    for (int i = 0; i < 10 && state_o != 3'd1; i++) tick();
    check("armed", state_o, 3'd1);
  endtask

  // stop_ch < 0: full readout; otherwise abort (use_abort) or withhold rdout_done on that channel
  task automatic run_seq(input int d, input int rd_dly, input int stop_ch, input bit use_abort,
                         input bit ar, input bit hv_drop);
    int len, last, col_t, t_rd;
    bit err;
    len  = (d + 1 < COLLECT_MAX) ? d + 1 : COLLECT_MAX;
    last = (stop_ch < 0) ? NUM_CH - 1 : stop_ch;
    exp_q.push_back(ev(2, 0, 0, 0, len));
    for (int c = 0; c <= last; c++) begin
      exp_q.push_back(ev(1, 0, (c == 0) ? 0 : 1, c, 1 << c));
      exp_q.push_back(ev(4, 0, 0, 0, (c == stop_ch && !use_abort) ? RD_TMO : rd_dly));
    end
    if (stop_ch < 0) m_cyc = (m_cyc + 1 > MAX_CYC) ? MAX_CYC : m_cyc + 1;
    err = (stop_ch >= 0) && !use_abort;
    exp_q.push_back(ev(3, err, CLR_CYCLES, m_cyc, (ar && !hv_drop) ? 1 : 0));

    auto_rearm = ar;
    reset_cmd  = 1'b1;
    tick();
    reset_cmd  = 1'b0;
    check("start_state", state_o, 3'd2);
    check("start_no_cnt", cnt_start, 1'b0);
    tick();
    check("collect_state", state_o, 3'd3);
    check("cnt_start_rise", cnt_start, 1'b1);
    check("seq_err_cleared", seq_err, 1'b0);
    if (hv_drop) hven_cmd = 1'b0;
    col_t = 0;
    t_rd  = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!busy) break;
      collect_done = (col_t == d);
      rdout_done   = 1'b0;
      abort_cmd    = 1'b0;
      if (rd_en != 0) begin
        t_rd++;
        if (t_rd == rd_dly) begin
          if (int'(rd_ch) == stop_ch) abort_cmd = use_abort;
          else rdout_done = 1'b1;
        end
      end else begin
        t_rd = 0;
      end
      col_t++;
      tick();
    end
    collect_done = 1'b0;
    rdout_done   = 1'b0;
    abort_cmd    = 1'b0;
    check("seq_done", busy, 1'b0);
    check("end_state", state_o, (ar && !hv_drop) ? 3'd1 : 3'd0);
    hven_cmd = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_cnt_start", cnt_start, 1'b0);
    check("rst_cnt_clr", cnt_clr, 1'b0);
    check("rst_rd_en", rd_en, '0);
    check("rst_rd_ch", rd_ch, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_cycle_cnt", cycle_cnt, '0);
    check("rst_seq_err", seq_err, 1'b0);
    check("rst_state", state_o, 3'd0);
    rst_n = 1'b1;
    tick();

    // collect_done at cycle 20, rdout_done 3 cycles after each rd_en rise
    go_armed();
    run_seq(19, 3, -1, 1'b0, 1'b0, 1'b0);
    // internal window limit only
    go_armed();
    run_seq(500, 2, -1, 1'b0, 1'b0, 1'b0);
    // three auto re-armed sequences; cycle_cnt saturates at all-ones
    go_armed();
    for (int i = 0; i < 3; i++) run_seq($urandom_range(0, 30), $urandom_range(1, 5), -1, 1'b0, 1'b1, 1'b0);
    // abort during readout of channel 2
    go_armed();
    run_seq(10, 3, 2, 1'b1, 1'b0, 1'b0);

`ifdef APES_ACQ_SEQ_RDTMO_EN
    go_armed();
    run_seq(5, 2, 1, 1'b0, 1'b0, 1'b0);
    go_armed();
    check("seq_err_sticky", seq_err, 1'b1);
    run_seq(3, 2, -1, 1'b0, 1'b0, 1'b0);
`endif

    // asynchronous reset in the middle of COLLECT
    go_armed();
    reset_cmd = 1'b1;
    tick();
    reset_cmd = 1'b0;
    repeat (6) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_cnt_start", cnt_start, 1'b0);
    check("arst_rd_ch", rd_ch, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_cycle_cnt", cycle_cnt, '0);
    check("arst_state", state_o, 3'd0);
    m_cyc = 0;
    tick();
    tick();
    rst_n = 1'b1;

    // randomized sequences against the event model
    for (int i = 0; i < 8; i++) begin
      int stop;
      go_armed();
      stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_CH - 1)) : -1;
      run_seq($urandom_range(0, 110), $urandom_range(1, 6), stop, 1'b1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // hven_cmd drop beats reset_cmd in ARMED
    go_armed();
    hven_cmd  = 1'b0;
    reset_cmd = 1'b1;
    tick();
    reset_cmd = 1'b0;
    check("hven_drop_state", state_o, 3'd0);
    check("hven_drop_cnt_start", cnt_start, 1'b0);
    tick();
    check("hven_drop_cnt_start2", cnt_start, 1'b0);
    check("hven_drop_busy", busy, 1'b0);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
